// File: rtl/trng_pkg.sv
// Shared types and helpers for the TRNG harvest controller.
package trng_pkg;

    localparam int unsigned N_SRC_DEF      = 4;
    localparam int unsigned SETTLE_CYC_DEF = 16;
    localparam int unsigned RCT_LIMIT_DEF  = 32;
    localparam int unsigned OUT_W_DEF      = 8;

    localparam int unsigned MAX_SRC   = 8;
    localparam int unsigned IDX_W_MAX = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE_A,
        ST_SAMPLE_B,
        ST_EMIT,
        ST_FAIL
    } state_e;

    typedef struct packed {
        logic                 found;
        logic [IDX_W_MAX-1:0] idx;
    } pick_t;

    // First non-faulty index after cur (ascending, wrapping, cur itself checked last).
    function automatic pick_t next_ok(input logic [MAX_SRC-1:0] faulty,
                                      input int unsigned        n_src,
                                      input int unsigned        cur);
        pick_t       r;
        int unsigned idx;
        r = '0;
        for (int unsigned i = 1; i <= MAX_SRC; i++) begin
            idx = cur + i;
            if (idx >= n_src) idx = idx - n_src;
            if ((i <= n_src) && !r.found && !faulty[IDX_W_MAX'(idx)]) begin
                r.found = 1'b1;
                r.idx   = IDX_W_MAX'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/trng_sync2.sv
// Two-flop synchronizer bank for asynchronous entropy source outputs.
module trng_sync2 #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/trng_harvest_ctrl.sv
// Sequences entropy sources one at a time, debiases their bits (von Neumann),
// runs a repetition-count health test and packs words onto a valid/ready port.
module trng_harvest_ctrl
    import trng_pkg::*;
#(
    parameter int unsigned N_SRC      = N_SRC_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned RCT_LIMIT  = RCT_LIMIT_DEF,
    parameter int unsigned OUT_W      = OUT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     clr_fault,
    input  logic [N_SRC-1:0]         raw_bits,
    output logic [N_SRC-1:0]         src_en,
    output logic [$clog2(N_SRC)-1:0] src_sel,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_SRC-1:0]         fault_mask,
    output logic                     alarm,
    output logic                     busy
);

    localparam int unsigned SEL_W = $clog2(N_SRC);
    localparam int unsigned CNT_W = $clog2(SETTLE_CYC);
    localparam int unsigned BC_W  = $clog2(OUT_W + 1);
    localparam int unsigned RCT_W = 8;

    state_e             state, state_n;
    logic [N_SRC-1:0]   raw_sync;
    logic [SEL_W-1:0]   src_sel_n;
    logic [N_SRC-1:0]   fault_n;
    pick_t              pick_low, pick_adv;
    logic [CNT_W-1:0]   settle_cnt;
    logic [BC_W-1:0]    bitcnt;
    logic [RCT_W-1:0]   rct_cnt;
    logic               rct_prev, rct_valid;
    logic               samp_a;
    logic [N_SRC-1:0]   src_en_d;
    logic               busy_d, alarm_d, out_valid_d;

    logic               smp_c, sampling_c, rct_hit_c, keep_c, word_done_c;
    logic [RCT_W-1:0]   rct_next_c;

    trng_sync2 #(.W(N_SRC)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_bits),
        .q     (raw_sync)
    );

    assign smp_c       = raw_sync[src_sel];
    assign sampling_c  = (state == ST_SAMPLE_A) || (state == ST_SAMPLE_B);
    assign rct_next_c  = (rct_valid && (smp_c == rct_prev)) ? RCT_W'(rct_cnt + RCT_W'(1)) : RCT_W'(1);
    assign rct_hit_c   = sampling_c && start && (rct_next_c == RCT_W'(RCT_LIMIT));
    assign keep_c      = (state == ST_SAMPLE_B) && (samp_a != smp_c);
    assign word_done_c = keep_c && (bitcnt == BC_W'(OUT_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next state, next source selection and fault accumulation.
    always_comb begin
        state_n   = state;
        src_sel_n = src_sel;
        fault_n   = fault_mask;
        if (rct_hit_c) fault_n = fault_mask | (N_SRC'(1) << src_sel);
        pick_low  = next_ok(MAX_SRC'(fault_mask), N_SRC, N_SRC - 1);
        pick_adv  = next_ok(MAX_SRC'(fault_n), N_SRC, 32'(src_sel));
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (pick_low.found) begin
                        state_n   = ST_SETTLE;
                        src_sel_n = SEL_W'(pick_low.idx);
                    end else begin
                        state_n = ST_FAIL;
                    end
                end
            end
            ST_SETTLE: begin
                if (!start)                                       state_n = ST_IDLE;
                else if (settle_cnt == CNT_W'(SETTLE_CYC - 1))    state_n = ST_SAMPLE_A;
            end
            ST_SAMPLE_A, ST_SAMPLE_B: begin
                if (!start) begin
                    state_n = ST_IDLE;
                end else if (rct_hit_c) begin
                    if (pick_adv.found) begin
                        state_n   = ST_SETTLE;
                        src_sel_n = SEL_W'(pick_adv.idx);
                    end else begin
                        state_n = ST_FAIL;
                    end
                end else if (state == ST_SAMPLE_A) begin
                    state_n = ST_SAMPLE_B;
                end else begin
                    state_n = word_done_c ? ST_EMIT : ST_SAMPLE_A;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (start) begin
                        state_n   = ST_SETTLE;
                        src_sel_n = SEL_W'(pick_adv.idx);
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_FAIL: begin
                if (clr_fault) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Registered-output values decoded from the upcoming state.
    always_comb begin
        src_en_d    = '0;
        busy_d      = 1'b0;
        alarm_d     = 1'b0;
        out_valid_d = 1'b0;
        case (state_n)
            ST_SETTLE, ST_SAMPLE_A, ST_SAMPLE_B: begin
                src_en_d = N_SRC'(1) << src_sel_n;
                busy_d   = 1'b1;
            end
            ST_EMIT: begin
                src_en_d    = N_SRC'(1) << src_sel_n;
                busy_d      = 1'b1;
                out_valid_d = 1'b1;
            end
            ST_FAIL: begin
                busy_d  = 1'b1;
                alarm_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_sel    <= '0;
            src_en     <= '0;
            busy       <= 1'b0;
            alarm      <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            fault_mask <= '0;
            settle_cnt <= '0;
            bitcnt     <= '0;
            rct_cnt    <= '0;
            rct_prev   <= 1'b0;
            rct_valid  <= 1'b0;
            samp_a     <= 1'b0;
        end else begin
            src_sel    <= src_sel_n;
            src_en     <= src_en_d;
            busy       <= busy_d;
            alarm      <= alarm_d;
            out_valid  <= out_valid_d;
            fault_mask <= clr_fault ? '0 : fault_n;
            settle_cnt <= ((state == ST_SETTLE) && (state_n == ST_SETTLE)) ?
                          CNT_W'(settle_cnt + CNT_W'(1)) : '0;
            if (state == ST_SAMPLE_A) samp_a <= smp_c;
            // Health-test history restarts with every newly settled source.
            if (state == ST_SETTLE) begin
                rct_cnt   <= '0;
                rct_valid <= 1'b0;
            end else if (sampling_c) begin
                rct_cnt   <= rct_next_c;
                rct_prev  <= smp_c;
                rct_valid <= 1'b1;
            end
            if (keep_c && ((state_n == ST_SAMPLE_A) || (state_n == ST_EMIT))) begin
                out_data <= {out_data[OUT_W-2:0], samp_a};
                bitcnt   <= BC_W'(bitcnt + BC_W'(1));
            end else if ((state_n != ST_SAMPLE_A) && (state_n != ST_SAMPLE_B) && (state_n != ST_EMIT)) begin
                bitcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_trng_harvest_ctrl.sv
// Self-checking bench for trng_harvest_ctrl: patterned sources, word scoreboard, corner sequences.
module tb_trng_harvest_ctrl;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         clr_fault;
    logic [N-1:0] raw_bits;
    logic [N-1:0] src_en;
    logic [1:0]   src_sel;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] fault_mask;
    logic         alarm;
    logic         busy;

    trng_harvest_ctrl #(
        .N_SRC      (4),
        .SETTLE_CYC (4),
        .RCT_LIMIT  (8),
        .OUT_W      (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clr_fault  (clr_fault),
        .raw_bits   (raw_bits),
        .src_en     (src_en),
        .src_sel    (src_sel),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fault_mask (fault_mask),
        .alarm      (alarm),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pat;
        int          len;
        logic [7:0]  exp_word;
    } vec_t;

    vec_t        vecs [N];
    logic [31:0] pat  [N];
    int          plen [N];
    logic [7:0]  sb   [$];
    int          edge_n;
    int          anc;
    int          n_tests;
    int          n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Raw value for the upcoming edge; pattern index 0 is the first sampled bit.
    task automatic drive_raw();
        int k;
        k = edge_n - anc;
        for (int s = 0; s < N; s++)
            raw_bits[s] = (k < 0) ? 1'b0 : pat[s][k % plen[s]];
    endtask

    task automatic tick();
        logic       hs;
        logic       start_pre;
        logic [7:0] d_pre;
        logic [1:0] sel_pre;
        logic [7:0] exp;
        int         e;
        drive_raw();
        hs        = rst_n && out_valid && out_ready;
        start_pre = start;
        d_pre     = out_data;
        sel_pre   = src_sel;
        e         = edge_n;
        @(posedge clk);
        #1;
        edge_n++;
        if ((hs && start_pre) || (busy && (src_sel != sel_pre))) anc = e + 3;
        if (hs) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got word 0x%0h, want none", d_pre);
            end else begin
                exp = sb.pop_front();
                check("sb_word", 32'(d_pre), 32'(exp));
            end
        end
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (!out_valid && waited < 400) begin
            tick();
            waited++;
        end
        check("valid_seen", 32'(out_valid), 1);
    endtask

    task automatic handshake(input logic keep_start);
        out_ready = 1'b1;
        start     = keep_start;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int waited;
        n_tests = 0;
        n_fail  = 0;
        edge_n  = 0;
        anc     = 1000;

        vecs[0] = '{32'h0000_0009, 4,  8'hAA};
        vecs[1] = '{32'h0000_0013, 6,  8'hFF};
        vecs[2] = '{32'h0000_0006, 4,  8'h55};
        vecs[3] = '{32'h0000_022D, 10, 8'h92};

        for (int s = 0; s < N; s++) begin
            pat[s]  = vecs[s].pat;
            plen[s] = vecs[s].len;
        end

        rst_n = 1'b0; start = 1'b0; clr_fault = 1'b0; out_ready = 1'b0; raw_bits = '0;
        repeat (3) tick();
        check("rst_src_en", 32'(src_en), 0);
        check("rst_src_sel", 32'(src_sel), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_fault", 32'(fault_mask), 0);
        check("rst_alarm", 32'(alarm), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Round robin over all four sources with the table patterns.
        for (int i = 0; i < N; i++) sb.push_back(vecs[i].exp_word);
        start = 1'b1;
        anc   = edge_n + 3;
        tick();
        check("start_src_en", 32'(src_en), 32'h1);
        check("start_busy", 32'(busy), 1);
        for (int i = 0; i < N; i++) begin
            wait_valid(waited);
            if (i == 0) begin
                check("first_word_latency", 32'(waited), 20);
                for (int c = 0; c < 20; c++) begin
                    tick();
                    check("hold_valid", 32'(out_valid), 1);
                    check("hold_data", 32'(out_data), 32'(vecs[0].exp_word));
                end
            end
            check("vec_word", 32'(out_data), 32'(vecs[i].exp_word));
            check("vec_emit_src_en", 32'(src_en), 32'(1 << i));
            handshake(1'b1);
            check("adv_src_sel", 32'(src_sel), 32'((i + 1) % N));
            check("adv_src_en", 32'(src_en), 32'(1 << ((i + 1) % N)));
            check("adv_valid_low", 32'(out_valid), 0);
        end
        start = 1'b0;
        tick();
        check("stop_settle_busy", 32'(busy), 0);
        check("stop_settle_src_en", 32'(src_en), 0);

        // Stop in SAMPLE_B with five bits collected, then a fresh full word.
        start = 1'b1;
        anc   = edge_n + 3;
        tick();
        repeat (15) tick();
        start = 1'b0;
        tick();
        check("stop_b_busy", 32'(busy), 0);
        check("stop_b_src_en", 32'(src_en), 0);
        check("stop_b_valid", 32'(out_valid), 0);
        sb.push_back(8'hAA);
        start = 1'b1;
        anc   = edge_n + 3;
        tick();
        wait_valid(waited);
        check("restart_latency", 32'(waited), 20);
        handshake(1'b0);
        check("emit_stop_busy", 32'(busy), 0);
        check("emit_stop_valid", 32'(out_valid), 0);

        // Source 1 stuck high after one good pair: fault, partial word dropped.
        pat[1]  = 32'hFFFF_FFFD;
        plen[1] = 32;
        sb.push_back(8'hAA);
        sb.push_back(8'h55);
        start = 1'b1;
        anc   = edge_n + 3;
        tick();
        wait_valid(waited);
        handshake(1'b1);
        waited = 0;
        while (fault_mask == '0 && waited < 200) begin
            tick();
            waited++;
        end
        check("rct_latency", 32'(waited), 14);
        check("rct_mask", 32'(fault_mask), 32'h2);
        check("rct_src_sel", 32'(src_sel), 2);
        check("rct_src_en", 32'(src_en), 32'h4);
        check("rct_valid_low", 32'(out_valid), 0);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        check("clr_run_mask", 32'(fault_mask), 0);
        check("clr_run_busy", 32'(busy), 1);
        check("clr_run_sel", 32'(src_sel), 2);
        wait_valid(waited);
        check("after_rct_word", 32'(out_data), 32'h55);
        handshake(1'b0);

        // Every source stuck: FAIL, then clr_fault back to IDLE.
        for (int s = 0; s < N; s++) begin
            pat[s]  = 32'hFFFF_FFFF;
            plen[s] = 32;
        end
        start = 1'b1;
        anc   = edge_n + 3;
        tick();
        waited = 0;
        while (!alarm && waited < 300) begin
            tick();
            waited++;
        end
        check("fail_alarm", 32'(alarm), 1);
        check("fail_mask", 32'(fault_mask), 32'hF);
        check("fail_src_en", 32'(src_en), 0);
        check("fail_valid", 32'(out_valid), 0);
        start = 1'b0;
        tick();
        check("fail_hold_alarm", 32'(alarm), 1);
        check("fail_hold_busy", 32'(busy), 1);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        check("fail_clr_mask", 32'(fault_mask), 0);
        check("fail_clr_alarm", 32'(alarm), 0);
        check("fail_clr_busy", 32'(busy), 0);

        // Asynchronous reset while a word is waiting in EMIT.
        pat[0]  = vecs[0].pat;
        plen[0] = vecs[0].len;
        sb.push_back(8'hAA);
        start = 1'b1;
        anc   = edge_n + 3;
        tick();
        wait_valid(waited);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_src_en", 32'(src_en), 0);
        check("arst_busy", 32'(busy), 0);
        sb.delete();
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_out_data", 32'(out_data), 0);
        check("arst_idle_valid", 32'(out_valid), 0);
        check("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
